pkt_arb_mux: RTL and testbench
==============================

// Module: pkt_arb_mux
// PURPOSE
//  Packet-level N:1 stream multiplexer. Sits directly downstream of the
//  round-robin `arbiter` and shares it. Drives the arbiter's request
//  vector from per-port stream valids, then latches the arbiter's
//  grant/select. Routes the owning port's packet to one shared master
//  stream until the beat with last, then releases ownership.
// PARAMETERS
//  NUM_PORTS   4                         number of slave (input) stream ports
//  DATA_WIDTH  32                        data bits per beat
//  SEL_WIDTH   max(1,$clog2(NUM_PORTS))  width of select/owner
// PORTS
//  clk          in   1             single clock, all logic posedge
//  rst_n        in   1             synchronous reset, active low
//  s_valid      in   NUM_PORTS     per-port beat valid
//  s_ready      out  NUM_PORTS     per-port beat ready
//  s_data       in   NUM_PORTS*DW  port p data at [p*DW +: DW]
//  s_last       in   NUM_PORTS     per-port end-of-packet
//  m_valid      out  1             shared output valid
//  m_ready      in   1             shared output ready
//  m_data       out  DATA_WIDTH    shared output data
//  m_last       out  1             shared output end-of-packet
//  arb_request  out  NUM_PORTS     to arbiter request, registered
//  arb_grant    in   NUM_PORTS     from arbiter grant, one-hot or 0
//  arb_select   in   SEL_WIDTH     from arbiter select
//  arb_active   in   1             from arbiter active
//  owner        out  SEL_WIDTH     current packet owner, valid when busy
//  busy         out  1             1 in XFER
//  proto_err    out  1             sticky: owner dropped s_valid with no handshake
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. arb_request, owner, busy,
//   proto_err, last_own_q=0. s_ready, m_valid=0 combinationally. Reset wins over all events.
//  FSM IDLE -> ARB0 -> ARB1 -> XFER -> IDLE:
//   IDLE: if |s_valid -> arb_request<=req_m, go ARB0; else arb_request<=0.
//   ARB0: arb_request<=req_m; go ARB1. This cycle absorbs the arbiter's
//    1-cycle registered latency, so stale grants are never sampled.
//   ARB1: if arb_active: owner<=arb_select, arb_request<=0, go XFER.
//    Otherwise arb_request<=req_m and stay.
//   XFER: m_valid=s_valid[owner], m_data/m_last=port owner,
//    s_ready[owner]=m_ready, all other s_ready=0. On beat
//    (m_valid&m_ready&m_last): last_own_q<=owner, go IDLE.
//  Fairness mask: req_m = s_valid & ~onehot(last_own_q) when
//   (s_valid & ~onehot(last_own_q)) != 0; otherwise req_m = s_valid.
//   This moves the arbiter token off a port that immediately re-requests.
//  Latency: s_valid rises at c0 with all else idle -> arb_request c1 ->
//   arb_grant c2 -> XFER c3, m_valid=1 at c3. Data path in XFER is
//   combinational (0 cycles). Min packet turnaround: last beat at t -> next m_valid at t+4.
//  Outside XFER: m_valid=0, s_ready=0, m_data=0, m_last=0.
//  Sources obey stream rule: valid is held until a handshake. In XFER,
//   s_valid[owner] 1->0 with no prior handshake sets proto_err=1 (sticky).
//   The FSM stays in XFER and waits.
//  A 1-beat packet (last on first beat) is legal and returns to IDLE.
//  Simultaneous requests are resolved only by the arbiter. This block never
//   decides priority itself.
//  Requests arriving during ARB0/ARB1 are merged into arb_request the next cycle.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with s_valid=4'hF -> arb_request=0,
//    m_valid=0, s_ready=0, busy=0, proto_err=0.
//  2 Single port 2, 3-beat packet D0..D2, m_ready=1 -> m_valid first at c3.
//    m_data=D0,D1,D2. m_last only on D2. owner=2. IDLE after D2.
//  3 Ports 0,1,3 each send 2-beat packets continuously -> output order
//    0,1,3,0,1,3. No interleaving of beats inside a packet.
//  4 Port 1 re-requests back-to-back while port 2 waits -> port 2 is served
//    before port 1's second packet (fairness mask).
//  5 m_ready toggles 1,0,0,1 mid-packet -> no beat lost or duplicated.
//    s_ready[owner] mirrors m_ready. Other s_ready stay 0.
//  6 Owner drops s_valid mid-beat with no handshake -> proto_err=1 and stays
//    1. Then rst_n=0 mid-XFER -> IDLE and proto_err=0 the next cycle.

Source files
------------

// File: rtl/pkt_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : pkt_arb_mux
// Purpose  : Packet-level N:1 stream mux that owns an external round-robin
//            arbiter's request/grant handshake and holds a port until last.
// Revision : 1.0  initial release
// ============================================================================
module pkt_arb_mux #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            s_valid,
   output logic [NUM_PORTS-1:0]            s_ready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
   input  logic [NUM_PORTS-1:0]            s_last,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic                            m_last,
   output logic [NUM_PORTS-1:0]            arb_request,
   input  logic [NUM_PORTS-1:0]            arb_grant,
   input  logic [SEL_WIDTH-1:0]            arb_select,
   input  logic                            arb_active,
   output logic [SEL_WIDTH-1:0]            owner,
   output logic                            busy,
   output logic                            proto_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB0 = 2'd1,
      ST_ARB1 = 2'd2,
      ST_XFER = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SEL_WIDTH-1:0] r_last_own;
   logic [SEL_WIDTH-1:0] w_last_own_nxt;
   logic [SEL_WIDTH-1:0] w_owner_nxt;
   logic [NUM_PORTS-1:0] w_req_nxt;
   logic [NUM_PORTS-1:0] w_req_m;
   logic [NUM_PORTS-1:0] w_masked;
   logic [NUM_PORTS-1:0] w_last_oh;
   logic                 r_pend;
   logic                 w_pend_nxt;
   logic                 w_err_set;
   logic                 w_own_valid;
   logic                 w_own_last;
   logic                 w_beat_last;
   logic                 w_unused_grant;

   // Ownership is taken from arb_select; the one-hot grant carries no extra information.
   assign w_unused_grant = ^arb_grant;

   // Steer the arbiter away from the port that just finished, unless it is the only requester.
   assign w_last_oh = NUM_PORTS'(1) << r_last_own;
   assign w_masked  = s_valid & ~w_last_oh;
   assign w_req_m   = (w_masked != '0) ? w_masked : s_valid;

   assign w_own_valid = s_valid[owner];
   assign w_own_last  = s_last[owner];
   assign busy        = (r_state == ST_XFER);
   assign w_beat_last = busy & w_own_valid & m_ready & w_own_last;

   // A beat offered without handshake must still be there next cycle.
   assign w_pend_nxt = busy & w_own_valid & ~m_ready;
   assign w_err_set  = busy & r_pend & ~w_own_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         arb_request <= '0;
         owner       <= '0;
         r_last_own  <= '0;
         r_pend      <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         arb_request <= w_req_nxt;
         owner       <= w_owner_nxt;
         r_last_own  <= w_last_own_nxt;
         r_pend      <= w_pend_nxt;
         if (w_err_set) begin
            proto_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = arb_request;
      w_owner_nxt    = owner;
      w_last_own_nxt = r_last_own;
      s_ready        = '0;
      m_valid        = 1'b0;
      m_data         = '0;
      m_last         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|s_valid) begin
               w_req_nxt   = w_req_m;
               w_state_nxt = ST_ARB0;
            end else begin
               w_req_nxt = '0;
            end
         end
         ST_ARB0: begin
            w_req_nxt   = w_req_m;
            w_state_nxt = ST_ARB1;
         end
         ST_ARB1: begin
            if (arb_active) begin
               w_owner_nxt = arb_select;
               w_req_nxt   = '0;
               w_state_nxt = ST_XFER;
            end else begin
               w_req_nxt = w_req_m;
            end
         end
         ST_XFER: begin
            m_valid        = w_own_valid;
            m_data         = s_data[owner*DATA_WIDTH +: DATA_WIDTH];
            m_last         = w_own_last;
            s_ready[owner] = m_ready;
            if (w_beat_last) begin
               w_last_own_nxt = owner;
               w_state_nxt    = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_pkt_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_arb_mux
// Purpose  : Bench for pkt_arb_mux with a behavioural round-robin arbiter,
//            randomized stream sources and a per-port packet scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_pkt_arb_mux;
   localparam int NP = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   typedef struct packed {
      logic [SW-1:0] own;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    s_valid = '0;
   logic [NP-1:0]    s_ready;
   logic [NP*DW-1:0] s_data = '0;
   logic [NP-1:0]    s_last = '0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [DW-1:0]    m_data;
   logic             m_last;
   logic [NP-1:0]    arb_request;
   logic [NP-1:0]    arb_grant;
   logic [SW-1:0]    arb_select;
   logic             arb_active;
   logic [SW-1:0]    owner;
   logic             busy;
   logic             proto_err;

   pkt_arb_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .arb_request(arb_request), .arb_grant(arb_grant), .arb_select(arb_select),
      .arb_active(arb_active), .owner(owner), .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // Round-robin arbiter: registered grant, held while the granted request stays up.
   int arb_ptr;
   function automatic int rr_pick(input logic [NP-1:0] req, input int last);
      int idx;
      for (int k = 1; k <= NP; k++) begin
         idx = (last + k) % NP;
         if (req[idx]) return idx;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         arb_grant <= '0;
         arb_ptr   <= NP - 1;
      end else if ((arb_request & arb_grant) != '0) begin
         arb_grant <= arb_grant;
      end else if (arb_request != '0) begin
         arb_grant <= NP'(1) << rr_pick(arb_request, arb_ptr);
         arb_ptr   <= rr_pick(arb_request, arb_ptr);
      end else begin
         arb_grant <= '0;
      end
   end

   always_comb begin
      arb_select = '0;
      for (int i = 0; i < NP; i++) if (arb_grant[i]) arb_select = SW'(i);
   end
   assign arb_active = |arb_grant;

   // Sources and scoreboard state
   logic [DW:0]   src_q [NP][$];
   logic [DW:0]   exp_q [NP][$];
   beat_t         out_q [$];
   logic          rdy_pat [$];
   logic [NP-1:0] present = '0;
   logic [NP-1:0] drop = '0;
   int            vprob = 100;
   int            rprob = 100;
   int            checks = 0;
   int            errors = 0;
   int            rdy_viol = 0;
   int            mv_viol = 0;
   logic          obs_mvalid, obs_busy, obs_perr, obs_mhs, obs_mlast;
   logic [NP-1:0] obs_req;

   task automatic add_pkt(input int p, input int n);
      logic [DW:0] b;
      for (int i = 0; i < n; i++) begin
         b = {(i == n - 1), 8'(p), 24'($urandom)};
         src_q[p].push_back(b);
         exp_q[p].push_back(b);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (!present[p] && src_q[p].size() > 0 && $urandom_range(99) < vprob) present[p] = 1'b1;
         s_valid[p] = present[p] & ~drop[p];
         if (present[p]) {s_last[p], s_data[p*DW +: DW]} = src_q[p][0];
         else begin
            s_last[p] = 1'b0;
            s_data[p*DW +: DW] = '0;
         end
      end
      if (rdy_pat.size() > 0) m_ready = rdy_pat.pop_front();
      else m_ready = ($urandom_range(99) < rprob) ? 1'b1 : 1'b0;
   endtask

   // One clock: observe mid-cycle, then retire handshakes and drive the next cycle.
   task automatic tick();
      logic [NP-1:0] hs;
      logic [NP-1:0] exp_rdy;
      logic [DW:0]   tmp;
      @(negedge clk);
      hs = s_valid & s_ready;
      exp_rdy = '0;
      if (busy) exp_rdy[owner] = m_ready;
      if (s_ready !== exp_rdy) rdy_viol++;
      if (busy) begin
         if (m_valid !== s_valid[owner] ||
             (m_valid && (m_data !== s_data[owner*DW +: DW] || m_last !== s_last[owner]))) mv_viol++;
      end else if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) mv_viol++;
      obs_mvalid = m_valid;
      obs_busy   = busy;
      obs_perr   = proto_err;
      obs_req    = arb_request;
      obs_mhs    = m_valid & m_ready;
      obs_mlast  = m_last;
      if (m_valid && m_ready) out_q.push_back(beat_t'({owner, m_last, m_data}));
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (hs[p]) begin
            tmp = src_q[p].pop_front();
            present[p] = 1'b0;
         end
      end
      drive();
   endtask

   task automatic clear_bench();
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
      end
      out_q.delete();
      rdy_pat.delete();
      present = '0; drop = '0;
      s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
      rdy_viol = 0; mv_viol = 0; vprob = 100; rprob = 100;
   endtask

   task automatic do_reset();
      clear_bench();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_bench();
      rst_n = 1'b0;
      s_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (arb_request !== 4'h0) begin errors++; $display("FAIL reset_arb_request: got %h expected 0", arb_request); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      checks++; if (s_ready !== 4'h0) begin errors++; $display("FAIL reset_s_ready: got %h expected 0", s_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
      s_valid = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_packet();
      int first;
      logic [NP-1:0] req1;
      beat_t exp_b;
      first = -1;
      req1 = '0;
      do_reset();
      add_pkt(2, 3);
      drive();
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 1) req1 = obs_req;
         if (obs_mvalid && first < 0) first = k;
      end
      checks++; if (first != 3) begin errors++; $display("FAIL single_latency: got first m_valid at c%0d expected c3", first); end
      checks++; if (req1 !== 4'b0100) begin errors++; $display("FAIL single_arb_request_c1: got %h expected 4", req1); end
      checks++; if (out_q.size() != 3) begin errors++; $display("FAIL single_beat_count: got %0d expected 3", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < 3; i++) begin
         exp_b = beat_t'({SW'(2), exp_q[2].pop_front()});
         checks++;
         if (out_q[i] !== exp_b) begin errors++; $display("FAIL single_beat%0d: got %h expected %h", i, out_q[i], exp_b); end
      end
      checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: busy got %b expected 0", obs_busy); end
   endtask

   task automatic test_round_robin();
      int ord[6];
      int ep;
      int n;
      beat_t exp_b;
      ord = '{0, 1, 3, 0, 1, 3};
      do_reset();
      add_pkt(0, 2); add_pkt(0, 2);
      drive();
      tick(); tick();
      add_pkt(1, 2); add_pkt(1, 2); add_pkt(3, 2); add_pkt(3, 2);
      n = 0;
      while (out_q.size() < 12 && n < 200) begin tick(); n++; end
      checks++; if (out_q.size() != 12) begin errors++; $display("FAIL rr_beat_count: got %0d expected 12", out_q.size()); end
      for (int j = 0; j < out_q.size() && j < 12; j++) begin
         ep = ord[j/2];
         exp_b = '0;
         if (exp_q[ep].size() > 0) exp_b = beat_t'({SW'(ep), exp_q[ep].pop_front()});
         checks++;
         if (out_q[j] !== exp_b) begin errors++; $display("FAIL rr_beat%0d: got %h expected %h", j, out_q[j], exp_b); end
      end
   endtask

   task automatic test_fairness();
      int fo[8];
      int t_last;
      int t_next;
      int k;
      beat_t exp_b;
      fo = '{1, 1, 1, 2, 2, 1, 1, 1};
      t_last = -1;
      t_next = -1;
      do_reset();
      add_pkt(1, 3); add_pkt(1, 3);
      drive();
      k = 0;
      while (out_q.size() < 8 && k < 80) begin
         tick();
         if (k == 3) add_pkt(2, 2);
         if (obs_mhs && obs_mlast && t_last < 0) t_last = k;
         else if (t_last >= 0 && t_next < 0 && obs_mvalid) t_next = k;
         k++;
      end
      checks++; if (out_q.size() != 8) begin errors++; $display("FAIL fair_beat_count: got %0d expected 8", out_q.size()); end
      checks++; if (t_next - t_last != 4) begin errors++; $display("FAIL fair_turnaround: got %0d cycles expected 4", t_next - t_last); end
      for (int j = 0; j < out_q.size() && j < 8; j++) begin
         exp_b = '0;
         if (exp_q[fo[j]].size() > 0) exp_b = beat_t'({SW'(fo[j]), exp_q[fo[j]].pop_front()});
         checks++;
         if (out_q[j] !== exp_b) begin errors++; $display("FAIL fair_beat%0d: got %h expected %h", j, out_q[j], exp_b); end
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] pat;
      int n;
      beat_t exp_b;
      do_reset();
      pat = 11'b111_1001_0011;
      for (int i = 10; i >= 0; i--) rdy_pat.push_back(pat[i]);
      add_pkt(0, 4);
      drive();
      n = 0;
      while (out_q.size() < 4 && n < 40) begin tick(); n++; end
      checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_beat_count: got %0d expected 4", out_q.size()); end
      for (int j = 0; j < out_q.size() && j < 4; j++) begin
         exp_b = beat_t'({SW'(0), exp_q[0].pop_front()});
         checks++;
         if (out_q[j] !== exp_b) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", j, out_q[j], exp_b); end
      end
      checks++; if (rdy_viol != 0) begin errors++; $display("FAIL bp_s_ready_rule: got %0d bad cycles expected 0", rdy_viol); end
      checks++; if (mv_viol != 0) begin errors++; $display("FAIL bp_m_path_rule: got %0d bad cycles expected 0", mv_viol); end
   endtask

   task automatic test_proto_err();
      int n;
      do_reset();
      rprob = 0;
      add_pkt(3, 3);
      drive();
      n = 0;
      do begin tick(); n++; end while (!obs_busy && n < 20);
      checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL perr_reach_xfer: busy got %b expected 1", obs_busy); end
      drop[3] = 1'b1;
      s_valid[3] = 1'b0;
      tick(); tick();
      checks++; if (obs_perr !== 1'b1) begin errors++; $display("FAIL perr_set: got %b expected 1", obs_perr); end
      checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL perr_stay_xfer: busy got %b expected 1", obs_busy); end
      drop[3] = 1'b0;
      s_valid[3] = present[3];
      tick(); tick();
      checks++; if (obs_perr !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", obs_perr); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL perr_reset_busy: got %b expected 0", busy); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_reset_clear: got %b expected 0", proto_err); end
      rst_n = 1'b1;
      clear_bench();
   endtask

   task automatic test_random();
      int total;
      int n;
      int tag;
      int ep;
      int cur;
      logic in_pkt;
      beat_t exp_b;
      do_reset();
      vprob = 60;
      rprob = 70;
      total = 0;
      for (int i = 0; i < 40; i++) begin
         n = int'($urandom_range(4, 1));
         add_pkt(int'($urandom_range(NP - 1)), n);
         total += n;
      end
      n = 0;
      while (out_q.size() < total && n < 4000) begin tick(); n++; end
      checks++; if (out_q.size() != total) begin errors++; $display("FAIL rand_beat_count: got %0d expected %0d", out_q.size(), total); end
      in_pkt = 1'b0;
      cur = 0;
      for (int j = 0; j < out_q.size(); j++) begin
         tag = int'(out_q[j].data[31:24]);
         ep = in_pkt ? cur : ((tag < NP) ? tag : 0);
         exp_b = '0;
         if (exp_q[ep].size() > 0) exp_b = beat_t'({SW'(ep), exp_q[ep].pop_front()});
         checks++;
         if (out_q[j] !== exp_b) begin errors++; $display("FAIL rand_beat%0d: got %h expected %h", j, out_q[j], exp_b); end
         in_pkt = ~out_q[j].last;
         cur = ep;
      end
      checks++; if (rdy_viol != 0) begin errors++; $display("FAIL rand_s_ready_rule: got %0d bad cycles expected 0", rdy_viol); end
      checks++; if (mv_viol != 0) begin errors++; $display("FAIL rand_m_path_rule: got %0d bad cycles expected 0", mv_viol); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rand_proto_err: got %b expected 0", proto_err); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_fairness();
      test_backpressure();
      test_proto_err();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
